id_regfile_bypass: RTL and testbench
====================================

Name: id_regfile_bypass

Overview:
- Consumer end of the writeback interface: the ID-stage register file that accepts the WB write bus and serves operand reads to decode.
- Holds 32 x 32-bit general registers and resolves RAW hazards by forwarding from the EX, MEM and WB forwarding buses.
- Raises a load-use stall request to the stall controller when an EX-stage load targets a source register being read.
- Sits between the WB stage (writer), the EX/MEM stages (forwarding sources) and the ID decode logic (reader).

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- DW, 32, data width.
- AW, 5, register address width; must satisfy 2^AW = NREG.
- FWD_EN, 1, 1 enables EX/MEM/WB bypass; 0 means reads return array contents only, and the load-use stall is still generated.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_to_rf_bus  in  38  {we[37], waddr[36:32], wdata[31:0]} from WB; already gated by the WB stall/bubble logic
- wb_to_id_bus  in  38  same packing as wb_to_rf_bus; the WB-stage forwarding source
- mem_to_id_bus  in  38  {we, waddr, wdata}; MEM-stage forwarding source
- ex_to_id_bus  in  39  {is_load[38], we[37], waddr[36:32], wdata[31:0]}; EX-stage forwarding source; wdata is invalid when is_load=1
- raddr1  in  5  read port 1 address (rs)
- raddr2  in  5  read port 2 address (rt)
- ren1  in  1  port 1 operand is actually used by the decoded instruction
- ren2  in  1  port 2 operand is actually used by the decoded instruction
- rdata1  out  32  port 1 operand
- rdata2  out  32  port 2 operand
- stallreq_id  out  1  load-use stall request to the stall controller

Behaviour:
- Storage: array of NREG x DW flops.
  - On posedge clk with rst=1: every entry is cleared to 0.
  - Otherwise, if we=1 and waddr!=0: entry[waddr] <= wdata.
  - A write to r0 is discarded.
  - The write takes effect at the clock edge, so a read in the same cycle as the write sees the old array value unless bypassed.
- Reads are combinational, zero latency. The per-port priority chain, first match wins:
  1. raddr==0 -> 0.
  2. FWD_EN=1, ex.we=1, ex.waddr==raddr, ex.is_load=0 -> ex.wdata.
  3. FWD_EN=1, mem.we=1, mem.waddr==raddr -> mem.wdata.
  4. FWD_EN=1, wb.we=1, wb.waddr==raddr -> wb.wdata. This also covers write-then-read in the same cycle.
  5. Otherwise -> array[raddr].
- The two ports are fully independent. raddr1==raddr2 must return identical data on both ports.
- Load-use detection:
  - stallreq_id = ex.is_load & ex.we & (ex.waddr!=0) & ((ren1 & raddr1==ex.waddr) | (ren2 & raddr2==ex.waddr)).
  - On a load hit, the rdata of the matching port falls through to MEM/WB/array. That value is don't-care because ID is held.
  - stallreq_id is purely combinational with no internal state. The next cycle's release happens naturally once the load has moved to MEM and its data is forwarded from mem_to_id_bus.
- Reset outputs: while rst=1, rdata1=rdata2=0 and stallreq_id=0, regardless of the bus inputs.
- Write port does not observe stall. Bubble suppression is the WB stage's responsibility: a zeroed bus has we=0.
- The WB write is the only state change. There is no internal stall state and no counters.
- Mid-operation reset: all registers read 0 starting the cycle after the reset edge. Writes presented during the rst cycle are lost.
- X-safety: when we=0, waddr/wdata are ignored by both the write port and the bypass logic.

Test Plan:
- Reset, then write r5=0x1234_5678 via wb_to_rf_bus, read raddr1=5 the next cycle -> rdata1=0x1234_5678. A read of r0 -> 0.
- Write r0=0xFFFF_FFFF with we=1 -> a later read of raddr1=0 returns 0; the array is unchanged.
- Same-cycle bypass priority: array r3=0x11, wb writes r3=0x22, mem r3=0x33, ex r3=0x44 (is_load=0), raddr1=raddr2=3.
  - Expect 0x44 on both ports.
  - Drop ex.we -> 0x33.
  - Drop mem.we -> 0x22.
  - Drop all -> 0x11; after the next edge, 0x22.
- Load-use: ex={is_load=1, we=1, waddr=7}, raddr2=7, ren2=1 -> stallreq_id=1.
  - Same with ren2=0 -> 0.
  - With ex.waddr=0 -> 0.
  - Next cycle, load in MEM (mem.wdata=0xABCD) -> stallreq_id=0 and rdata2=0xABCD.
- FWD_EN=0 build: ex/mem/wb all target r9 with distinct data, array r9=0x55 -> rdata1=0x55. Load-use on r9 still asserts stallreq_id.
- Reset mid-run: fill r1..r31 with their index values, assert rst for 1 cycle with a concurrent wb write r4=0x99.
  - During rst, outputs = 0.
  - After rst, every register reads 0, including r4.

Source files
------------

// File: rtl/id_regfile_bypass.sv
// ID-stage register file with EX/MEM/WB operand bypass and load-use stall request.
// Register 0 always reads zero. The WB write lands at the clock edge, so a read in
// the same cycle sees it only through the WB bypass path.
module id_regfile_bypass #(
    parameter int NREG   = 32,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW+DW:0]    wb_to_rf_bus,
    input  logic [AW+DW:0]    wb_to_id_bus,
    input  logic [AW+DW:0]    mem_to_id_bus,
    input  logic [AW+DW+1:0]  ex_to_id_bus,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    input  logic              ren1,
    input  logic              ren2,
    output logic [DW-1:0]     rdata1,
    output logic [DW-1:0]     rdata2,
    output logic              stallreq_id
);

    // Field extraction for the write bus and the three forwarding sources.
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          ex_is_load;
    logic          ex_we;
    logic [AW-1:0] ex_waddr;
    logic [DW-1:0] ex_wdata;

    assign rf_we      = wb_to_rf_bus[AW+DW];
    assign rf_waddr   = wb_to_rf_bus[AW+DW-1:DW];
    assign rf_wdata   = wb_to_rf_bus[DW-1:0];
    assign wb_we      = wb_to_id_bus[AW+DW];
    assign wb_waddr   = wb_to_id_bus[AW+DW-1:DW];
    assign wb_wdata   = wb_to_id_bus[DW-1:0];
    assign mem_we     = mem_to_id_bus[AW+DW];
    assign mem_waddr  = mem_to_id_bus[AW+DW-1:DW];
    assign mem_wdata  = mem_to_id_bus[DW-1:0];
    assign ex_is_load = ex_to_id_bus[AW+DW+1];
    assign ex_we      = ex_to_id_bus[AW+DW];
    assign ex_waddr   = ex_to_id_bus[AW+DW-1:DW];
    assign ex_wdata   = ex_to_id_bus[DW-1:0];

    // Register storage: one flop row per architectural register.
    logic [DW-1:0] reg_q [NREG];
    logic [DW-1:0] reg_d [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // r0 is hardwired to zero; writes to it are dropped.
                always_comb reg_d[gi] = '0;

                // r0 row held at zero.
                always_ff @(posedge clk) reg_q[gi] <= '0;
            end else begin : g_row
                // Next value: take WB write data when this row is addressed.
                always_comb begin
                    reg_d[gi] = reg_q[gi];
                    if (rf_we && (rf_waddr == AW'(gi))) begin
                        reg_d[gi] = rf_wdata;
                    end
                end

                // Row register, cleared by synchronous reset.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        reg_q[gi] <= '0;
                    end else begin
                        reg_q[gi] <= reg_d[gi];
                    end
                end
            end
        end
    endgenerate

    // Read ports, indexed so both share one generate body.
    logic [AW-1:0] raddr_p [2];
    logic          ren_p   [2];
    logic [DW-1:0] rdata_p [2];
    logic          hit_p   [2];

    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;
    assign ren_p[0]   = ren1;
    assign ren_p[1]   = ren2;
    assign rdata1     = rdata_p[0];
    assign rdata2     = rdata_p[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Operand mux: lowest priority assigned first so later matches override,
            // giving r0 > EX (non-load) > MEM > WB > array.
            always_comb begin
                rdata_p[gi] = reg_q[raddr_p[gi]];
                if (FWD_EN) begin
                    if (wb_we && (wb_waddr == raddr_p[gi])) begin
                        rdata_p[gi] = wb_wdata;
                    end
                    if (mem_we && (mem_waddr == raddr_p[gi])) begin
                        rdata_p[gi] = mem_wdata;
                    end
                    if (ex_we && !ex_is_load && (ex_waddr == raddr_p[gi])) begin
                        rdata_p[gi] = ex_wdata;
                    end
                end
                if ((raddr_p[gi] == '0) || rst) begin
                    rdata_p[gi] = '0;
                end
            end

            // Port depends on the register an in-flight EX load will produce.
            always_comb begin
                hit_p[gi] = ren_p[gi] && (raddr_p[gi] == ex_waddr);
            end
        end
    endgenerate

    // Load-use stall: an EX load to a nonzero register that decode is about to read.
    always_comb begin
        stallreq_id = 1'b0;
        if (!rst && ex_is_load && ex_we && (ex_waddr != '0)) begin
            stallreq_id = hit_p[0] || hit_p[1];
        end
    end

endmodule

// File: tb/tb_id_regfile_bypass.sv
// Scoreboard bench for id_regfile_bypass: a driver issues one stimulus per cycle and
// pushes the reference model's expectation; a monitor pops and compares mid-cycle.
// Two instances run side by side, one with bypass enabled and one without.
module tb_id_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] wb_to_rf_bus;
    logic [37:0] wb_to_id_bus;
    logic [37:0] mem_to_id_bus;
    logic [38:0] ex_to_id_bus;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        ren1;
    logic        ren2;
    logic [31:0] rdata1_f, rdata2_f, rdata1_n, rdata2_n;
    logic        stall_f, stall_n;

    always #5 clk = ~clk;

    id_regfile_bypass #(.FWD_EN(1'b1)) dut_fwd (
        .clk(clk), .rst(rst),
        .wb_to_rf_bus(wb_to_rf_bus), .wb_to_id_bus(wb_to_id_bus),
        .mem_to_id_bus(mem_to_id_bus), .ex_to_id_bus(ex_to_id_bus),
        .raddr1(raddr1), .raddr2(raddr2), .ren1(ren1), .ren2(ren2),
        .rdata1(rdata1_f), .rdata2(rdata2_f), .stallreq_id(stall_f)
    );

    id_regfile_bypass #(.FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .rst(rst),
        .wb_to_rf_bus(wb_to_rf_bus), .wb_to_id_bus(wb_to_id_bus),
        .mem_to_id_bus(mem_to_id_bus), .ex_to_id_bus(ex_to_id_bus),
        .raddr1(raddr1), .raddr2(raddr2), .ren1(ren1), .ren2(ren2),
        .rdata1(rdata1_n), .rdata2(rdata2_n), .stallreq_id(stall_n)
    );

    typedef struct packed {
        logic        rst;
        logic        rf_we;  logic [4:0] rf_a;  logic [31:0] rf_d;
        logic        wb_we;  logic [4:0] wb_a;  logic [31:0] wb_d;
        logic        mem_we; logic [4:0] mem_a; logic [31:0] mem_d;
        logic        ex_ld;  logic       ex_we; logic [4:0] ex_a; logic [31:0] ex_d;
        logic [4:0]  r1;     logic [4:0] r2;    logic ren1;       logic ren2;
    } stim_t;

    typedef struct packed {
        logic [31:0] r1_f; logic [31:0] r2_f; logic s_f;
        logic [31:0] r1_n; logic [31:0] r2_n; logic s_n;
        logic [15:0] txn;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [32];
    int          checks = 0;
    int          passes = 0;
    int          txn_cnt = 0;

    // Reference: what decode should see for one read given the architectural state.
    function automatic logic [31:0] ref_read(input stim_t s, input logic [4:0] a, input bit fwd);
        if (s.rst || a == 5'd0) return 32'd0;
        if (fwd) begin
            if (s.ex_we && !s.ex_ld && s.ex_a == a) return s.ex_d;
            if (s.mem_we && s.mem_a == a) return s.mem_d;
            if (s.wb_we && s.wb_a == a) return s.wb_d;
        end
        return model_mem[a];
    endfunction

    function automatic logic ref_stall(input stim_t s);
        if (s.rst || !s.ex_ld || !s.ex_we || s.ex_a == 5'd0) return 1'b0;
        return (s.ren1 && s.r1 == s.ex_a) || (s.ren2 && s.r2 == s.ex_a);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle, record the expectation, then advance the model past the edge.
    task automatic issue(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = s.rst;
        wb_to_rf_bus  = {s.rf_we, s.rf_a, s.rf_d};
        wb_to_id_bus  = {s.wb_we, s.wb_a, s.wb_d};
        mem_to_id_bus = {s.mem_we, s.mem_a, s.mem_d};
        ex_to_id_bus  = {s.ex_ld, s.ex_we, s.ex_a, s.ex_d};
        raddr1        = s.r1;
        raddr2        = s.r2;
        ren1          = s.ren1;
        ren2          = s.ren2;
        e.r1_f = ref_read(s, s.r1, 1'b1);
        e.r2_f = ref_read(s, s.r2, 1'b1);
        e.s_f  = ref_stall(s);
        e.r1_n = ref_read(s, s.r1, 1'b0);
        e.r2_n = ref_read(s, s.r2, 1'b0);
        e.s_n  = ref_stall(s);
        e.txn  = 16'(txn_cnt);
        txn_cnt++;
        sb.push_back(e);
        if (s.rst) begin
            for (int k = 0; k < 32; k++) model_mem[k] = 32'd0;
        end else if (s.rf_we && s.rf_a != 5'd0) begin
            model_mem[s.rf_a] = s.rf_d;
        end
    endtask

    task automatic chk(input string name, input int txn, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s txn %0d: got %h expected %h", name, txn, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so one result is presented per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rdata1_fwd", int'(e.txn), rdata1_f, e.r1_f);
                chk("rdata2_fwd", int'(e.txn), rdata2_f, e.r2_f);
                chk("stall_fwd", int'(e.txn), {31'd0, stall_f}, {31'd0, e.s_f});
                chk("rdata1_nofwd", int'(e.txn), rdata1_n, e.r1_n);
                chk("rdata2_nofwd", int'(e.txn), rdata2_n, e.r2_n);
                chk("stall_nofwd", int'(e.txn), {31'd0, stall_n}, {31'd0, e.s_n});
                $display("txn %0d: rdata1=%h rdata2=%h stall=%0b", e.txn, rdata1_f, rdata2_f, stall_f);
            end
        end
    end

    // Directed test plan followed by randomized traffic.
    initial begin
        stim_t s;
        int    wait_cycles;
        for (int k = 0; k < 32; k++) model_mem[k] = 32'd0;
        rst = 1'b1;
        wb_to_rf_bus = '0; wb_to_id_bus = '0; mem_to_id_bus = '0; ex_to_id_bus = '0;
        raddr1 = '0; raddr2 = '0; ren1 = 1'b0; ren2 = 1'b0;

        // Reset with noisy buses: outputs must still be zero.
        s = idle(); s.rst = 1'b1; s.ex_we = 1'b1; s.ex_a = 5'd3; s.ex_d = 32'hDEAD;
        s.r1 = 5'd3; s.r2 = 5'd3; s.ren1 = 1'b1; s.ren2 = 1'b1;
        issue(s);
        s = idle(); s.rst = 1'b1; issue(s);

        // Write r5, read it back; r0 reads zero.
        s = idle(); s.rf_we = 1'b1; s.rf_a = 5'd5; s.rf_d = 32'h1234_5678; issue(s);
        s = idle(); s.r1 = 5'd5; s.r2 = 5'd0; s.ren1 = 1'b1; issue(s);

        // Write to r0 is discarded.
        s = idle(); s.rf_we = 1'b1; s.rf_a = 5'd0; s.rf_d = 32'hFFFF_FFFF; issue(s);
        s = idle(); s.r1 = 5'd0; s.r2 = 5'd5; issue(s);

        // Bypass priority on r3.
        s = idle(); s.rf_we = 1'b1; s.rf_a = 5'd3; s.rf_d = 32'h11; issue(s);
        s = idle(); s.r1 = 5'd3; s.r2 = 5'd3;
        s.wb_we = 1'b1; s.wb_a = 5'd3; s.wb_d = 32'h22;
        s.mem_we = 1'b1; s.mem_a = 5'd3; s.mem_d = 32'h33;
        s.ex_we = 1'b1; s.ex_a = 5'd3; s.ex_d = 32'h44;
        issue(s);
        s.ex_we = 1'b0; issue(s);
        s.mem_we = 1'b0; issue(s);
        s.wb_we = 1'b0; issue(s);
        s.rf_we = 1'b1; s.rf_a = 5'd3; s.rf_d = 32'h22; s.wb_we = 1'b1; issue(s);
        s = idle(); s.r1 = 5'd3; s.r2 = 5'd3; issue(s);

        // Load-use detection and release.
        s = idle(); s.ex_ld = 1'b1; s.ex_we = 1'b1; s.ex_a = 5'd7; s.ex_d = 32'hBAD;
        s.r1 = 5'd1; s.r2 = 5'd7; s.ren2 = 1'b1; issue(s);
        s.ren2 = 1'b0; issue(s);
        s.ren2 = 1'b1; s.ex_a = 5'd0; s.r2 = 5'd0; issue(s);
        s = idle(); s.mem_we = 1'b1; s.mem_a = 5'd7; s.mem_d = 32'hABCD;
        s.r2 = 5'd7; s.ren2 = 1'b1; issue(s);

        // r9 in array, all buses target r9: no-bypass instance must return the array.
        s = idle(); s.rf_we = 1'b1; s.rf_a = 5'd9; s.rf_d = 32'h55; issue(s);
        s = idle(); s.r1 = 5'd9; s.r2 = 5'd9; s.ren1 = 1'b1;
        s.wb_we = 1'b1; s.wb_a = 5'd9; s.wb_d = 32'h91;
        s.mem_we = 1'b1; s.mem_a = 5'd9; s.mem_d = 32'h92;
        s.ex_we = 1'b1; s.ex_a = 5'd9; s.ex_d = 32'h93;
        issue(s);
        s.ex_ld = 1'b1; issue(s);

        // Fill r1..r31, reset with a concurrent write to r4, read everything back.
        for (int k = 1; k < 32; k++) begin
            s = idle(); s.rf_we = 1'b1; s.rf_a = 5'(k); s.rf_d = 32'(k);
            s.r1 = 5'(k - 1); s.r2 = 5'(k); issue(s);
        end
        s = idle(); s.rst = 1'b1; s.rf_we = 1'b1; s.rf_a = 5'd4; s.rf_d = 32'h99;
        s.r1 = 5'd4; s.r2 = 5'd31; s.ren1 = 1'b1; s.ren2 = 1'b1; issue(s);
        for (int k = 0; k < 32; k += 2) begin
            s = idle(); s.r1 = 5'(k); s.r2 = 5'(k + 1); issue(s);
        end

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 39) == 0);
            s.rf_we  = 1'($urandom); s.rf_a  = 5'($urandom_range(0, 7)); s.rf_d  = $urandom;
            s.wb_we  = 1'($urandom); s.wb_a  = 5'($urandom_range(0, 7)); s.wb_d  = $urandom;
            s.mem_we = 1'($urandom); s.mem_a = 5'($urandom_range(0, 7)); s.mem_d = $urandom;
            s.ex_ld  = ($urandom_range(0, 3) == 0);
            s.ex_we  = 1'($urandom); s.ex_a  = 5'($urandom_range(0, 7)); s.ex_d  = $urandom;
            s.r1     = 5'($urandom_range(0, 9));
            s.r2     = 5'($urandom_range(0, 9));
            s.ren1   = 1'($urandom);
            s.ren2   = 1'($urandom);
            issue(s);
        end

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
